// File: rtl/sevenseg_pkg.sv
// Shared register layout and segment encoding for the seven-segment scanner.
// Segment patterns are active-high with bit 6 = g down to bit 0 = a.
package sevenseg_pkg;

    localparam int VAL_LSB   = 0;
    localparam int VAL_W     = 4;
    localparam int DP_BIT    = 4;
    localparam int BLANK_BIT = 5;
    localparam int EN_BIT    = 0;

    // Index 15 is leftmost: F, E, d, C, b, A, 9 .. 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sevenseg_scanner_if.sv
// kcpsm6 port-mapped I/O bus as seen by a peripheral (slave) and the processor (master).
interface sevenseg_scanner_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] in_port;

    modport master (output port_id, output out_port, output write_strobe, input in_port);
    modport slave  (input port_id, input out_port, input write_strobe, output in_port);
endinterface

// File: rtl/seg_hex_decode.sv
// Hex digit to active-high seven-segment pattern (g..a), polarity-neutral.
module seg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    assign pattern = SEG_TABLE[value];

endmodule

// File: rtl/sevenseg_scanner.sv
// N-digit multiplexed seven-segment controller with kcpsm6 register access.
// Each slot blanks for BLANK_CYCLES before driving the latched digit to the pins.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int         NUM_DIGITS     = 4,
    parameter int         SCAN_DIV       = 1024,
    parameter int         BLANK_CYCLES   = 16,
    parameter logic [7:0] BASE_PORT      = 8'h83,
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter bit         AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scanner_if.slave     bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int         CNT_W     = $clog2(SCAN_DIV);
    localparam int         IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CTRL_PORT = 8'(int'(BASE_PORT) + NUM_DIGITS);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("sevenseg_scanner: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("sevenseg_scanner: SCAN_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES > SCAN_DIV - 1) begin : g_bad_blank
        $error("sevenseg_scanner: BLANK_CYCLES must be 0..SCAN_DIV-1");
    end
    if (int'(BASE_PORT) + NUM_DIGITS > 255) begin : g_bad_port
        $error("sevenseg_scanner: control port address exceeds 8'hFF");
    end

    logic [5:0]            digit_r [NUM_DIGITS];
    logic                  en_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [5:0]            latch_r;
    logic [5:0]            latch_next_s;
    logic [7:0]            rd_s;
    logic [6:0]            pattern_s;
    logic                  in_blank_s;
    logic                  off_s;
    logic [7:0]            seg_on_s;
    logic [NUM_DIGITS-1:0] an_on_s;

    // Register file: digit registers and control, written by matching port writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= 6'h00;
            end
            en_r <= 1'b1;
        end else if (bus.write_strobe) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.port_id == 8'(int'(BASE_PORT) + i)) begin
                    digit_r[i] <= bus.out_port[5:0];
                end
            end
            if (bus.port_id == CTRL_PORT) begin
                en_r <= bus.out_port[EN_BIT];
            end
        end
    end

    // Readback mux; unmatched addresses read as zero
    always_comb begin
        rd_s = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            rd_s = rd_s | ({8{bus.port_id == 8'(int'(BASE_PORT) + i)}} & {2'b00, digit_r[i]});
        end
        rd_s = rd_s | ({8{bus.port_id == CTRL_PORT}} & {7'h00, en_r});
    end

    // Slot counter and digit index; both run regardless of the enable bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Latch reloads at slot start from the pre-write register value
    assign latch_next_s = (cnt_r == {CNT_W{1'b0}}) ? digit_r[idx_r] : latch_r;

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank_s = 1'b0;
    end else begin : g_blank
        assign in_blank_s = (cnt_r < CNT_W'(BLANK_CYCLES));
    end

    assign off_s = in_blank_s | ~en_r | latch_next_s[BLANK_BIT];

    seg_hex_decode u_decode (
        .value   (latch_next_s[VAL_LSB +: VAL_W]),
        .pattern (pattern_s)
    );

    // Active-high pin image before polarity adjustment
    always_comb begin
        if (off_s) begin
            seg_on_s = 8'h00;
            an_on_s  = {NUM_DIGITS{1'b0}};
        end else begin
            seg_on_s = {latch_next_s[DP_BIT], pattern_s};
            an_on_s  = NUM_DIGITS'(1) << idx_r;
        end
    end

    // Display latch, registered pins and registered readback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_r     <= 6'h00;
            seg         <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
            an          <= AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
            bus.in_port <= 8'h00;
        end else begin
            latch_r     <= latch_next_s;
            seg         <= SEG_ACTIVE_LOW ? ~seg_on_s : seg_on_s;
            an          <= AN_ACTIVE_LOW ? ~an_on_s : an_on_s;
            bus.in_port <= rd_s;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with 4 digits, 16-cycle slots and 2 blank cycles.
module tb_sevenseg_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg;
    logic [3:0] an;
    int         edge_cnt;
    int         total = 0;
    int         bad   = 0;

    sevenseg_scanner_if bus ();

    sevenseg_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (16),
        .BLANK_CYCLES   (2),
        .BASE_PORT      (8'h83),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .seg (seg),
        .an  (an)
    );

    always #5 clk = ~clk;

    // Edges since reset release; pins after edge k show slot (k-1)/16, cycle (k-1)%16
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Active-low patterns for 0..F with dp off
    logic [7:0] seg_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic [5:0] dig   [4];
    logic [5:0] shown [4];
    logic       en_m;

    typedef struct {
        logic [7:0] wport;
        logic [7:0] wdata;
        logic [7:0] rport;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            dig[i]   = 6'h00;
            shown[i] = 6'h00;
        end
        en_m = 1'b1;
    endtask

    // One clock: checks the pins against the slot expectation, then applies any write seen at the edge
    task automatic tick();
        logic       wr;
        logic [7:0] p, dta, es;
        logic [3:0] ea;
        int         k, d, c;
        wr  = bus.write_strobe;
        p   = bus.port_id;
        dta = bus.out_port;
        @(negedge clk);
        k = edge_cnt;
        d = ((k - 1) / 16) % 4;
        c = (k - 1) % 16;
        if (c == 0) shown[d] = dig[d];
        if (c < 2 || !en_m || shown[d][5]) begin
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            es = seg_lo[shown[d][3:0]];
            if (shown[d][4]) es[7] = 1'b0;
            ea = ~(4'b0001 << d);
        end
        check($sformatf("pins@%0d an/seg", k), {20'h0, an, seg}, {20'h0, ea, es});
        if (wr) begin
            if (p >= 8'h83 && p <= 8'h86) dig[int'(p - 8'h83)] = dta[5:0];
            else if (p == 8'h87) en_m = dta[0];
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) tick();
    endtask

    function automatic int next_at(input int dgt, input int cyc);
        int k;
        k = edge_cnt + 1;
        while (((k - 1) % 64) != 16 * dgt + cyc) k++;
        return k;
    endfunction

    task automatic write_reg(input logic [7:0] p, input logic [7:0] dt);
        bus.port_id      = p;
        bus.out_port     = dt;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] p, input logic [7:0] exp);
        bus.port_id = p;
        tick();
        check(name, {24'h0, bus.in_port}, {24'h0, exp});
    endtask

    initial begin
        vecs[0] = '{8'h84, 8'h1A, 8'h84, 8'h1A};
        vecs[1] = '{8'h85, 8'hFF, 8'h85, 8'h3F};
        vecs[2] = '{8'h86, 8'hC7, 8'h86, 8'h07};
        vecs[3] = '{8'h87, 8'hFE, 8'h87, 8'h00};
        vecs[4] = '{8'h87, 8'h03, 8'h87, 8'h01};
        vecs[5] = '{8'h83, 8'h0C, 8'h90, 8'h00};
        vecs[6] = '{8'h90, 8'h77, 8'h82, 8'h00};
        vecs[7] = '{8'h8B, 8'h12, 8'h83, 8'h0C};

        rst              = 1'b1;
        bus.port_id      = 8'h00;
        bus.out_port     = 8'h00;
        bus.write_strobe = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("reset seg", {24'h0, seg}, 32'h0000_00FF);
        check("reset an", {28'h0, an}, 32'h0000_000F);
        check("reset in_port", {24'h0, bus.in_port}, 32'h0000_0000);
        rst = 1'b0;

        run(3);
        check("first slot an", {28'h0, an}, 32'h0000_000E);
        check("first slot seg", {24'h0, seg}, 32'h0000_00C0);

        // Scan order with 1..4 on the four digits
        write_reg(8'h83, 8'h01);
        write_reg(8'h84, 8'h02);
        write_reg(8'h85, 8'h03);
        write_reg(8'h86, 8'h04);
        run(128);
        goto_edge(next_at(0, 5));
        check("digit0 an", {28'h0, an}, 32'h0000_000E);
        check("digit0 seg", {24'h0, seg}, 32'h0000_00F9);
        goto_edge(next_at(1, 1));
        check("slot1 blank an", {28'h0, an}, 32'h0000_000F);
        goto_edge(next_at(3, 2));
        check("digit3 an", {28'h0, an}, 32'h0000_0007);

        // Register write / readback table
        for (int i = 0; i < 8; i++) begin
            write_reg(vecs[i].wport, vecs[i].wdata);
            read_chk($sformatf("readback[%0d]", i), vecs[i].rport, vecs[i].exp);
        end

        // Blank flag, then dp with value 5
        write_reg(8'h85, 8'h25);
        run(128);
        goto_edge(next_at(2, 8));
        check("blank digit2 an", {28'h0, an}, 32'h0000_000F);
        write_reg(8'h85, 8'h15);
        run(128);
        goto_edge(next_at(2, 8));
        check("dp digit2 an", {28'h0, an}, 32'h0000_000B);
        check("dp digit2 seg", {24'h0, seg}, 32'h0000_0012);

        // Disable for over a frame, then resume mid-scan
        goto_edge(next_at(1, 7));
        write_reg(8'h87, 8'h00);
        run(80);
        write_reg(8'h87, 8'h01);
        run(70);

        // Mid-slot write to the digit being shown, then a write on the latch edge
        goto_edge(next_at(1, 5));
        write_reg(8'h84, 8'h09);
        goto_edge(next_at(1, 10));
        check("midslot old an", {28'h0, an}, 32'h0000_000D);
        check("midslot old seg", {24'h0, seg}, 32'h0000_0008);
        begin
            int e;
            e = next_at(1, 0);
            goto_edge(e - 1);
            write_reg(8'h84, 8'h0E);
        end
        goto_edge(next_at(1, 5));
        check("latch edge old seg", {24'h0, seg}, 32'h0000_0090);
        goto_edge(next_at(1, 5));
        check("latch edge new seg", {24'h0, seg}, 32'h0000_0086);

        // Asynchronous reset in the middle of a slot
        goto_edge(next_at(2, 7));
        read_chk("pre-reset in_port", 8'h83, 8'h0C);
        #2 rst = 1'b1;
        #1;
        check("async reset seg", {24'h0, seg}, 32'h0000_00FF);
        check("async reset an", {28'h0, an}, 32'h0000_000F);
        check("async reset in_port", {24'h0, bus.in_port}, 32'h0000_0000);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        run(3);
        check("post-reset an", {28'h0, an}, 32'h0000_000E);
        check("post-reset seg", {24'h0, seg}, 32'h0000_00C0);
        read_chk("post-reset rd ctrl", 8'h87, 8'h01);
        run(64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
